mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL expose these ports (name direction width meaning), clock and reset first:
  mc_clk  in  1  single clock, all logic on rising edge
  mc_reset  in  1  synchronous, active-high reset
  ctrl_data_contition  in  3  command from core control: 100 store, 010 transfer, 001 processing, 000 idle
  mc_data_length  in  6  words to store, sampled when the store command is accepted
  mc_data_in  in  8  input data word
  mc_data_in_valid  in  1  mc_data_in holds a valid word this cycle
  mc_done  out  1  one-cycle pulse: store or transfer complete
  mc_data_done  out  1  level: every stored word has been transferred
  mc_reg_data  out  32  register batch; word0 in [7:0] ... word3 in [31:24]
  mc_reg_count  out  3  valid words in mc_reg_data, 0..4
REQ-002 SHALL use one clock, mc_clk, with synchronous active-high reset mc_reset.

Function
REQ-003 SHALL implement a state machine with states IDLE, STORE, READ, LOAD and HOLD.
REQ-004 IDLE, condition 100: SHALL latch mc_data_length into len, clear wr_ptr, rd_ptr and mc_data_done, and enter STORE.
REQ-005 IDLE, condition 010: SHALL clear mc_reg_data and mc_reg_count, and enter READ.
REQ-006 IDLE, condition 001 or 000: SHALL stay in IDLE; mc_reg_data and mc_reg_count SHALL hold.
REQ-007 STORE: each cycle with mc_data_in_valid=1 and wr_ptr<len SHALL write mc_data_in to mem[wr_ptr] and increment wr_ptr.
REQ-008 STORE: in the cycle after wr_ptr reaches len, SHALL pulse mc_done for exactly one cycle and enter HOLD.
REQ-009 STORE with len=0: SHALL pulse mc_done on the cycle after entry, set mc_data_done=1, and write nothing.
REQ-010 READ: SHALL issue a read of mem[rd_ptr] and increment rd_ptr; memory read latency is 1 cycle.
REQ-011 LOAD: SHALL place each returned word into slot mc_reg_count and increment mc_reg_count.
REQ-012 Transfer SHALL stop at 4 words or when rd_ptr reaches len, whichever comes first.
REQ-013 Transfer completion SHALL pulse mc_done for one cycle, then enter HOLD.
REQ-014 Transfer latency SHALL be k+1 cycles from command detection to mc_done, for k words.
REQ-015 mc_data_done SHALL be set in the same cycle as the mc_done pulse that ends the transfer with rd_ptr==len.
REQ-016 mc_data_done SHALL remain set until the next accepted store command or reset.
REQ-017 Transfer with rd_ptr==len on entry SHALL pulse mc_done after 1 cycle with mc_reg_count=0 and mc_data_done=1.
REQ-018 HOLD: SHALL stay until ctrl_data_contition differs from the completed command, then return to IDLE; a repeated command SHALL NOT restart.
REQ-019 Command change mid-STORE/READ/LOAD (abort): SHALL return to IDLE with no mc_done pulse; pointers SHALL retain their values.
REQ-020 Codes 011, 101, 110 and 111 SHALL be treated as 000.
REQ-021 mc_data_in_valid SHALL be ignored outside STORE.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 mc_reset SHALL force IDLE and clear mc_done, mc_data_done, mc_reg_data, mc_reg_count, wr_ptr, rd_ptr and len.
REQ-024 Reset mid-operation SHALL abort with no mc_done pulse; memory contents are not cleared.

Structure
REQ-025 Package mc_pkg SHALL hold the condition codes (CMD_IDLE, CMD_STORE, CMD_TRANS, CMD_PROC), state encodings, and MEM_DEPTH=64, WORD_W=8, BATCH=4.
REQ-026 Storage SHALL be sub-module mc_mem: 64x8 synchronous RAM, one write port, one registered read port.

Verification
REQ-027 Store: condition 100, length 6, words 0x11..0x16 on consecutive valid cycles -> a single mc_done pulse one cycle after the 6th write; mem[0..5]=0x11..0x16.
REQ-028 Transfer: after REQ-027, condition 010 -> mc_done 5 cycles later; mc_reg_data=0x14131211, mc_reg_count=4, mc_data_done=0.
REQ-029 Loop: conditions 001 then 010 -> mc_done 3 cycles later; mc_reg_data=0x00001615, mc_reg_count=2, mc_data_done=1 on the same cycle.
REQ-030 Hold: condition 100 kept high 5 cycles after mc_done -> no second pulse and no pointer change.
REQ-031 Zero length: condition 100 with length 0 -> mc_done after 1 cycle and mc_data_done=1; a following 010 -> mc_done after 1 cycle with mc_reg_count=0.
REQ-032 Abort/reset: condition changes to 000 after 2 of 6 store words -> IDLE, no mc_done; mc_reset asserted mid-transfer -> all outputs zero on the next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared command codes, state encodings and sizing for mem_controller
//
// Purpose: one place for the core-control command codes, the controller FSM
// encoding and the storage/batch geometry used by mem_controller and mc_mem.
// Ports: none (package).
package mc_pkg;

  localparam int MEM_DEPTH = 64;
  localparam int WORD_W    = 8;
  localparam int BATCH     = 4;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_PROC  = 3'b001,
    CMD_TRANS = 3'b010,
    CMD_STORE = 3'b100
  } mc_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_READ  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4
  } mc_state_e;

  // Any code that is not one of the three one-hot commands behaves as idle.
  function automatic mc_cmd_e cmd_decode(input logic [2:0] raw);
    case (raw)
      3'b100:  return CMD_STORE;
      3'b010:  return CMD_TRANS;
      3'b001:  return CMD_PROC;
      default: return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem.sv
// rtl/mc_mem.sv - 64x8 synchronous RAM, one write port, one registered read port
//
// Purpose: word storage for mem_controller; contents survive reset.
// Ports:
//   mc_clk     in   clock
//   wr_en      in   write mem[wr_addr] <= wr_data this edge
//   wr_addr    in   write address
//   wr_data    in   write word
//   rd_en      in   load rd_data <= mem[rd_addr] this edge
//   rd_addr    in   read address
//   rd_data    out  registered read word, valid the cycle after rd_en
module mc_mem
  import mc_pkg::*;
(
  input  logic              mc_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge mc_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - store/transfer controller between core control and a 64x8 buffer
//
// Purpose: stores a burst of words on the store command, then hands them back
// in batches of up to four on each transfer command.
// Ports:
//   mc_clk               in   clock, rising edge
//   mc_reset             in   synchronous active-high reset
//   ctrl_data_contition  in   command: 100 store, 010 transfer, 001 processing, else idle
//   mc_data_length       in   words to store, sampled when store is accepted
//   mc_data_in           in   store data word
//   mc_data_in_valid     in   mc_data_in is valid (only used while storing)
//   mc_done              out  one-cycle pulse when a store or transfer completes
//   mc_data_done         out  level, every stored word has been transferred
//   mc_reg_data          out  transfer batch, word0 in [7:0] .. word3 in [31:24]
//   mc_reg_count         out  valid words in mc_reg_data
module mem_controller
  import mc_pkg::*;
(
  input  logic                    mc_clk,
  input  logic                    mc_reset,
  input  logic [2:0]              ctrl_data_contition,
  input  logic [ADDR_W-1:0]       mc_data_length,
  input  logic [WORD_W-1:0]       mc_data_in,
  input  logic                    mc_data_in_valid,
  output logic                    mc_done,
  output logic                    mc_data_done,
  output logic [BATCH*WORD_W-1:0] mc_reg_data,
  output logic [2:0]              mc_reg_count
);

  mc_state_e         state, state_next;
  mc_cmd_e           cmd, held_cmd;
  logic [ADDR_W-1:0] len, wr_ptr, rd_ptr;
  logic [WORD_W-1:0] mem_rdata;
  logic              wr_en, rd_en, capture, finish;

  assign cmd = cmd_decode(ctrl_data_contition);

  mc_mem u_mem (
    .mc_clk  (mc_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (mc_data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // READ issues the first read of a batch; LOAD captures the word returned by
  // the previous edge and, while the batch has room and words remain, issues
  // the next read in the same cycle, so k words take k+1 cycles.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd == CMD_STORE) begin
          state_next = ST_STORE;
        end else if (cmd == CMD_TRANS) begin
          state_next = ST_READ;
        end
      end
      ST_STORE: begin
        if (cmd != CMD_STORE) begin
          state_next = ST_IDLE;
        end else if (wr_ptr == len) begin
          finish     = 1'b1;
          state_next = ST_HOLD;
        end else begin
          wr_en = mc_data_in_valid;
        end
      end
      ST_READ: begin
        if (cmd != CMD_TRANS) begin
          state_next = ST_IDLE;
        end else if (rd_ptr == len) begin
          finish     = 1'b1;
          state_next = ST_HOLD;
        end else begin
          rd_en      = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cmd != CMD_TRANS) begin
          state_next = ST_IDLE;
        end else begin
          capture = 1'b1;
          if (mc_reg_count < 3'(BATCH - 1) && rd_ptr != len) begin
            rd_en = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cmd != held_cmd) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mc_clk) begin
    if (mc_reset) begin
      held_cmd     <= CMD_IDLE;
      len          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mc_done      <= 1'b0;
      mc_data_done <= 1'b0;
      mc_reg_data  <= '0;
      mc_reg_count <= '0;
    end else begin
      mc_done <= finish;
      if (state == ST_IDLE && cmd == CMD_STORE) begin
        held_cmd     <= CMD_STORE;
        len          <= mc_data_length;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        mc_data_done <= 1'b0;
      end
      if (state == ST_IDLE && cmd == CMD_TRANS) begin
        held_cmd     <= CMD_TRANS;
        mc_reg_data  <= '0;
        mc_reg_count <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (capture) begin
        for (int i = 0; i < BATCH; i++) begin
          if (mc_reg_count == 3'(i)) begin
            mc_reg_data[i*WORD_W +: WORD_W] <= mem_rdata;
          end
        end
        mc_reg_count <= mc_reg_count + 3'd1;
      end
      // A zero-length store leaves nothing to transfer; a transfer that ends
      // with the read pointer at the length has drained the buffer.
      if (finish && ((state == ST_STORE) ? (len == '0) : (rd_ptr == len))) begin
        mc_data_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - self-checking bench for mem_controller
module tb_mem_controller;

  logic        mc_clk = 1'b0;
  logic        mc_reset;
  logic [2:0]  ctrl_data_contition;
  logic [5:0]  mc_data_length;
  logic [7:0]  mc_data_in;
  logic        mc_data_in_valid;
  logic        mc_done;
  logic        mc_data_done;
  logic [31:0] mc_reg_data;
  logic [2:0]  mc_reg_count;

  int total = 0;
  int bad   = 0;

  // Reference state: buffer contents, stored length, words already handed out.
  logic [7:0] m_mem [64];
  int         m_len;
  int         m_rd;
  bit         m_dd;

  logic [2:0] idle_codes [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b110, 3'b111};

  mem_controller dut (
    .mc_clk              (mc_clk),
    .mc_reset            (mc_reset),
    .ctrl_data_contition (ctrl_data_contition),
    .mc_data_length      (mc_data_length),
    .mc_data_in          (mc_data_in),
    .mc_data_in_valid    (mc_data_in_valid),
    .mc_done             (mc_done),
    .mc_data_done        (mc_data_done),
    .mc_reg_data         (mc_reg_data),
    .mc_reg_count        (mc_reg_count)
  );

  always #5 mc_clk = ~mc_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mc_clk);
    #1;
  endtask

  function automatic logic [2:0] idle_code();
    return idle_codes[$urandom_range(0, 5)];
  endfunction

  task automatic do_store(input int len, input bit rnd, input int hold_cyc);
    int         gaps;
    logic [7:0] d;
    ctrl_data_contition = 3'b100;
    mc_data_length      = 6'(len);
    mc_data_in_valid    = 1'b0;
    step();
    mc_data_length = 6'($urandom);
    for (int i = 0; i < len; i++) begin
      gaps = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        mc_data_in_valid = 1'b0;
        mc_data_in       = 8'($urandom);
        step();
        chk("store_busy", 32'(mc_done), 32'(0));
      end
      d = rnd ? 8'($urandom) : 8'(8'h11 + i);
      mc_data_in       = d;
      mc_data_in_valid = 1'b1;
      step();
      m_mem[i] = d;
      chk("store_busy", 32'(mc_done), 32'(0));
    end
    mc_data_in_valid = rnd ? 1'($urandom) : 1'b0;
    mc_data_in       = 8'($urandom);
    step();
    chk("store_done", 32'(mc_done), 32'(1));
    chk("store_data_done", 32'(mc_data_done), 32'(len == 0));
    m_len = len;
    m_rd  = 0;
    m_dd  = (len == 0);
    for (int h = 0; h < hold_cyc; h++) begin
      mc_data_in_valid = 1'($urandom);
      mc_data_in       = 8'($urandom);
      step();
      chk("store_hold", 32'(mc_done), 32'(0));
    end
    ctrl_data_contition = idle_code();
    mc_data_in_valid    = 1'b0;
    step();
    chk("store_release", 32'(mc_done), 32'(0));
  endtask

  task automatic do_trans(input logic [2:0] rel);
    int          k;
    logic [31:0] ed;
    bit          edd;
    k = m_len - m_rd;
    if (k > 4) k = 4;
    ed = 32'h0;
    for (int j = 0; j < k; j++) begin
      ed = ed | (32'(m_mem[m_rd + j]) << (8 * j));
    end
    edd = m_dd || (m_rd + k == m_len);
    ctrl_data_contition = 3'b010;
    mc_data_in_valid    = 1'($urandom);
    mc_data_in          = 8'($urandom);
    step();
    for (int c = 1; c <= k + 1; c++) begin
      mc_data_in_valid = 1'($urandom);
      step();
      if (c <= k) chk("trans_busy", 32'(mc_done), 32'(0));
    end
    chk("trans_done", 32'(mc_done), 32'(1));
    chk("trans_data", mc_reg_data, ed);
    chk("trans_count", 32'(mc_reg_count), 32'(k));
    chk("trans_data_done", 32'(mc_data_done), 32'(edd));
    step();
    chk("trans_hold", 32'(mc_done), 32'(0));
    ctrl_data_contition = rel;
    mc_data_in_valid    = 1'b0;
    step();
    chk("trans_release", 32'(mc_done), 32'(0));
    m_rd = m_rd + k;
    m_dd = edd;
    step();
    chk("idle_keep_data", mc_reg_data, ed);
    chk("idle_keep_count", 32'(mc_reg_count), 32'(k));
  endtask

  initial begin
    int len;
    int n;
    mc_reset            = 1'b1;
    ctrl_data_contition = 3'b000;
    mc_data_length      = 6'd0;
    mc_data_in          = 8'd0;
    mc_data_in_valid    = 1'b0;
    m_len = 0;
    m_rd  = 0;
    m_dd  = 1'b0;
    step();
    step();
    chk("reset_done", 32'(mc_done), 32'(0));
    chk("reset_data_done", 32'(mc_data_done), 32'(0));
    chk("reset_data", mc_reg_data, 32'h0);
    chk("reset_count", 32'(mc_reg_count), 32'(0));
    mc_reset = 1'b0;
    step();

    // Nothing stored yet: transfer completes empty.
    do_trans(3'b000);

    // Directed store of 0x11..0x16, held 5 cycles after completion.
    do_store(6, 1'b0, 5);
    do_trans(3'b001);
    chk("first_batch_data", mc_reg_data, 32'h14131211);
    chk("first_batch_count", 32'(mc_reg_count), 32'(4));
    chk("first_batch_dd", 32'(mc_data_done), 32'(0));
    do_trans(3'b000);
    chk("second_batch_data", mc_reg_data, 32'h00001615);
    chk("second_batch_count", 32'(mc_reg_count), 32'(2));
    chk("second_batch_dd", 32'(mc_data_done), 32'(1));
    do_trans(3'b011);

    // Zero-length store then transfer.
    do_store(0, 1'b0, 2);
    do_trans(3'b000);
    chk("zero_len_count", 32'(mc_reg_count), 32'(0));

    // Store aborted after 2 of 6 words; older words beyond them survive.
    ctrl_data_contition = 3'b100;
    mc_data_length      = 6'd6;
    step();
    mc_data_in_valid = 1'b1;
    mc_data_in       = 8'hA1;
    step();
    chk("abort_busy", 32'(mc_done), 32'(0));
    mc_data_in = 8'hA2;
    step();
    chk("abort_busy", 32'(mc_done), 32'(0));
    m_mem[0] = 8'hA1;
    m_mem[1] = 8'hA2;
    m_len = 6;
    m_rd  = 0;
    m_dd  = 1'b0;
    ctrl_data_contition = 3'b000;
    mc_data_in_valid    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", 32'(mc_done), 32'(0));
    end
    chk("abort_data_done", 32'(mc_data_done), 32'(0));
    do_trans(3'b000);
    chk("after_abort_data", mc_reg_data, 32'h1413A2A1);

    // Reset in the middle of a two-word transfer.
    ctrl_data_contition = 3'b010;
    step();
    step();
    mc_reset            = 1'b1;
    ctrl_data_contition = 3'b000;
    step();
    chk("midreset_done", 32'(mc_done), 32'(0));
    chk("midreset_data_done", 32'(mc_data_done), 32'(0));
    chk("midreset_data", mc_reg_data, 32'h0);
    chk("midreset_count", 32'(mc_reg_count), 32'(0));
    mc_reset = 1'b0;
    step();
    chk("midreset_no_done", 32'(mc_done), 32'(0));
    m_len = 0;
    m_rd  = 0;
    m_dd  = 1'b0;
    do_trans(3'b000);

    // Randomized store/transfer rounds.
    for (int it = 0; it < 12; it++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      do_store(len, 1'b1, int'($urandom_range(0, 3)));
      n = (len + 3) / 4 + int'($urandom_range(0, 1));
      for (int t = 0; t < n; t++) begin
        do_trans(idle_code());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
